// File: rtl/usb_ep_pkg.sv
// usb_ep_pkg: shared endpoint FSM encoding and ring-pointer distance helper.
package usb_ep_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} ep_state_e;
  function automatic int ptr_dist(input int a, input int b, input int abits);
    return (a - b) & ((1 << (abits + 1)) - 1);
  endfunction
endpackage

// File: rtl/ep_sdpram.sv
// ep_sdpram: simple dual-port RAM, one write port, one registered read port with enable.
module ep_sdpram #(
  parameter int W = 9,
  parameter int A = 4
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         re_i,
  input  logic [A-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);
  logic [W-1:0] mem [2**A];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/bulk_ep_out_pkt.sv
// bulk_ep_out_pkt: USB bulk OUT packet buffer with commit/rollback and ACK/NAK flow control.
// Define BULK_EP_OUT_PKT_STATS_EN to add saturating pkt_count_o/drop_count_o outputs.
module bulk_ep_out_pkt
  import usb_ep_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ABITS   = 11,
  parameter int MAX_PKT = 512
) (
  input  logic             bulk_ep_out_clock,
  input  logic             reset_n,
  input  logic             bulk_ep_out_xfer_i,
  input  logic             bulk_ep_out_abort_i,
  output logic             bulk_ep_out_ready_read_o,
  input  logic             bulk_ep_out_tvalid_i,
  output logic             bulk_ep_out_tready_o,
  input  logic             bulk_ep_out_tlast_i,
  input  logic [WIDTH-1:0] bulk_ep_out_tdata_i,
  output logic             axis_tvalid_o,
  input  logic             axis_tready_i,
  output logic             axis_tlast_o,
  output logic [WIDTH-1:0] axis_tdata_o,
  output logic             status_full_o,
  output logic [ABITS:0]   level_o
`ifdef BULK_EP_OUT_PKT_STATS_EN
  ,
  output logic [15:0]      pkt_count_o,
  output logic [15:0]      drop_count_o
`endif
);
  localparam logic [ABITS:0] MAXP = MAX_PKT[ABITS:0];
  ep_state_e state_q, state_d;
  logic [ABITS:0] rd_q, rd_d, cm_q, cm_d, wr_q, wr_d, fe_q, fe_d, len_q, len_d, level_q;
  logic [WIDTH:0] od_q, od_d, ram_q;
  logic ready_q, full_q, v1_q, v1_d, ov_q, ov_d;
  logic acc, we, re, out_rdy, pop, commit, drop, mem_full;
  function automatic logic space_ok(input logic [ABITS:0] w, input logic [ABITS:0] r);
    return (1 << ABITS) - ptr_dist(int'(w), int'(r), ABITS) >= MAX_PKT;
  endfunction
  assign mem_full = ptr_dist(int'(wr_q), int'(rd_q), ABITS) == (1 << ABITS);
  // The overflowing word is never written, so it may be accepted even when memory is full.
  assign bulk_ep_out_tready_o = (state_q == DROP) || (state_q == RECV && (!mem_full || len_q == MAXP));
  always_comb begin
    acc = bulk_ep_out_tvalid_i && bulk_ep_out_tready_o;
    state_d = state_q;
    wr_d = wr_q;
    cm_d = cm_q;
    len_d = len_q;
    we = 1'b0;
    commit = 1'b0;
    drop = 1'b0;
    case (state_q)
      IDLE: if (bulk_ep_out_xfer_i) begin
        state_d = ready_q ? RECV : DROP;
        len_d = '0;
        drop = !ready_q;
      end
      RECV: if (bulk_ep_out_abort_i) begin
        state_d = IDLE;
        wr_d = cm_q;
        drop = 1'b1;
      end else if (acc && len_q == MAXP) begin
        state_d = bulk_ep_out_tlast_i ? IDLE : DROP;
        wr_d = cm_q;
        drop = 1'b1;
      end else if (acc) begin
        we = 1'b1;
        wr_d = wr_q + 1'b1;
        len_d = len_q + 1'b1;
        if (bulk_ep_out_tlast_i) begin
          state_d = IDLE;
          cm_d = wr_q + 1'b1;
          commit = 1'b1;
        end
      end
      default: if (bulk_ep_out_abort_i || (acc && bulk_ep_out_tlast_i)) state_d = IDLE;
    endcase
  end
  // Two-stage egress: RAM read register (v1) feeding the output register (ov).
  always_comb begin
    pop = ov_q && axis_tready_i;
    out_rdy = !ov_q || axis_tready_i;
    re = (fe_q != cm_q) && (!v1_q || out_rdy);
    fe_d = re ? fe_q + 1'b1 : fe_q;
    v1_d = re || (v1_q && !out_rdy);
    ov_d = out_rdy ? v1_q : ov_q;
    od_d = (out_rdy && v1_q) ? ram_q : od_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge bulk_ep_out_clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      {rd_q, cm_q, wr_q, fe_q, len_q, level_q} <= '0;
      od_q <= '0;
      {v1_q, ov_q, full_q} <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      cm_q <= cm_d;
      wr_q <= wr_d;
      fe_q <= fe_d;
      len_q <= len_d;
      level_q <= cm_d - rd_d;
      od_q <= od_d;
      v1_q <= v1_d;
      ov_q <= ov_d;
      ready_q <= (state_d == IDLE) && space_ok(wr_d, rd_d);
      full_q <= !space_ok(wr_d, rd_d);
    end
  end
`ifdef BULK_EP_OUT_PKT_STATS_EN
  logic [15:0] pkt_q, drop_q;
  always_ff @(posedge bulk_ep_out_clock) begin
    if (!reset_n) begin
      pkt_q <= '0;
      drop_q <= '0;
    end else begin
      pkt_q <= (commit && pkt_q != '1) ? pkt_q + 1'b1 : pkt_q;
      drop_q <= (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end
  end
  assign pkt_count_o = pkt_q;
  assign drop_count_o = drop_q;
`endif
  ep_sdpram #(.W(WIDTH + 1), .A(ABITS)) u_ram (
    .clk_i  (bulk_ep_out_clock),
    .we_i   (we),
    .waddr_i(wr_q[ABITS-1:0]),
    .wdata_i({bulk_ep_out_tlast_i, bulk_ep_out_tdata_i}),
    .re_i   (re),
    .raddr_i(fe_q[ABITS-1:0]),
    .rdata_o(ram_q)
  );
  assign bulk_ep_out_ready_read_o = ready_q;
  assign status_full_o = full_q;
  assign level_o = level_q;
  assign axis_tvalid_o = ov_q;
  assign axis_tdata_o = od_q[WIDTH-1:0];
  assign axis_tlast_o = od_q[WIDTH];
endmodule

// File: tb/tb_bulk_ep_out_pkt.sv
// tb_bulk_ep_out_pkt: directed self-checking bench for bulk_ep_out_pkt (WIDTH=8, ABITS=4, MAX_PKT=8).
module tb_bulk_ep_out_pkt;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic xfer = 1'b0, abort = 1'b0, tv = 1'b0, tl = 1'b0, atready = 1'b0;
  logic [7:0] td = '0;
  logic ready, tready, avalid, alast, full;
  logic [7:0] adata;
  logic [4:0] level;
`ifdef BULK_EP_OUT_PKT_STATS_EN
  logic [15:0] pkt_cnt, drop_cnt;
`endif
  int checks = 0;
  int errors = 0;

  bulk_ep_out_pkt #(.WIDTH(8), .ABITS(4), .MAX_PKT(8)) dut (
    .bulk_ep_out_clock       (clk),
    .reset_n                 (rst_n),
    .bulk_ep_out_xfer_i      (xfer),
    .bulk_ep_out_abort_i     (abort),
    .bulk_ep_out_ready_read_o(ready),
    .bulk_ep_out_tvalid_i    (tv),
    .bulk_ep_out_tready_o    (tready),
    .bulk_ep_out_tlast_i     (tl),
    .bulk_ep_out_tdata_i     (td),
    .axis_tvalid_o           (avalid),
    .axis_tready_i           (atready),
    .axis_tlast_o            (alast),
    .axis_tdata_o            (adata),
    .status_full_o           (full),
    .level_o                 (level)
`ifdef BULK_EP_OUT_PKT_STATS_EN
    ,
    .pkt_count_o             (pkt_cnt),
    .drop_count_o            (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    int n = 0;
    tv = 1'b1;
    td = d;
    tl = l;
    while (!tready && n < 20) begin
      tick();
      n++;
    end
    chk("put_ready", 32'(tready), 1);
    tick();
  endtask

  task automatic pkt(input logic [7:0] base, input int n, input logic last);
    for (int i = 0; i < n; i++) put(base + 8'(i), last && i == n - 1);
    tv = 1'b0;
    tl = 1'b0;
  endtask

  task automatic start();
    xfer = 1'b1;
    tick();
    xfer = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_tready"}, 32'(tready), 0);
    chk({tag, "_avalid"}, 32'(avalid), 0);
    chk({tag, "_alast"}, 32'(alast), 0);
    chk({tag, "_adata"}, 32'(adata), 0);
  endtask

  logic [7:0] nak_exp [8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h40, 8'h41, 8'h42, 8'h43};
  logic [7:0] c_lvl [15] = '{0, 0, 0, 0, 4, 4, 4, 3, 5, 4, 3, 2, 1, 0, 0};
  logic       c_val [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic [7:0] c_dat [15] = '{0, 0, 0, 0, 0, 0, 8'h70, 8'h71, 8'h72, 8'h73, 8'h80, 8'h81, 8'h82, 0, 0};
  logic       c_lst [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};

  initial begin
    tick();
    tick();
    reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Commit of a 5-word packet, egress held off so the level stays at its peak
    start();
    chk("commit_ready_busy", 32'(ready), 0);
    chk("commit_tready", 32'(tready), 1);
    pkt(8'h10, 5, 1'b1);
    chk("commit_level", 32'(level), 5);
    chk("commit_ready_idle", 32'(ready), 1);
    chk("commit_tready_idle", 32'(tready), 0);
    tick();
    tick();
    atready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("commit_avalid", 32'(avalid), 1);
      chk("commit_adata", 32'(adata), 32'h10 + i);
      chk("commit_alast", 32'(alast), 32'(i == 4));
      tick();
    end
    chk("commit_drained_valid", 32'(avalid), 0);
    chk("commit_drained_level", 32'(level), 0);
    atready = 1'b0;

    // Rollback of 3 uncommitted words
    start();
    pkt(8'h20, 3, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tick();
    chk("abort_level", 32'(level), 0);
    chk("abort_avalid", 32'(avalid), 0);
    chk("abort_ready", 32'(ready), 1);
    chk("abort_tready", 32'(tready), 0);
`ifdef BULK_EP_OUT_PKT_STATS_EN
    chk("abort_drop_cnt", 32'(drop_cnt), 1);
`endif

    // NAK: 9 committed words leave 7 free slots, fewer than MAX_PKT
    start();
    pkt(8'h30, 5, 1'b1);
    start();
    pkt(8'h40, 4, 1'b1);
    chk("nak_level", 32'(level), 9);
    chk("nak_ready", 32'(ready), 0);
    chk("nak_full", 32'(full), 1);
    chk("nak_avalid", 32'(avalid), 1);
    chk("nak_head", 32'(adata), 32'h30);
    start();
    chk("nak_drop_tready", 32'(tready), 1);
    chk("nak_drop_ready", 32'(ready), 0);
    pkt(8'h50, 2, 1'b1);
    chk("nak_drop_level", 32'(level), 9);
    chk("nak_drop_idle", 32'(tready), 0);
`ifdef BULK_EP_OUT_PKT_STATS_EN
    chk("nak_drop_cnt", 32'(drop_cnt), 2);
`endif
    atready = 1'b1;
    tick();
    atready = 1'b0;
    chk("nak_drain_ready", 32'(ready), 1);
    chk("nak_drain_full", 32'(full), 0);
    chk("nak_drain_level", 32'(level), 8);
    atready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("nak_drain_data", 32'(adata), 32'(nak_exp[i]));
      tick();
    end
    chk("nak_empty_valid", 32'(avalid), 0);
    chk("nak_empty_level", 32'(level), 0);
    atready = 1'b0;

    // Oversize: word 9 forces DROP, terminated by tlast on word 10
    start();
    pkt(8'h60, 9, 1'b0);
    chk("over_drop_tready", 32'(tready), 1);
    chk("over_drop_ready", 32'(ready), 0);
    chk("over_drop_level", 32'(level), 0);
    put(8'h69, 1'b1);
    tv = 1'b0;
    tl = 1'b0;
    chk("over_idle_tready", 32'(tready), 0);
    chk("over_idle_ready", 32'(ready), 1);
    tick();
    tick();
    chk("over_level", 32'(level), 0);
    chk("over_avalid", 32'(avalid), 0);
`ifdef BULK_EP_OUT_PKT_STATS_EN
    chk("over_drop_cnt", 32'(drop_cnt), 3);
`endif

    // Concurrency: two commits while egress reads every cycle
    atready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      xfer = (k == 0 || k == 5);
      tv = (k >= 1 && k <= 4) || (k >= 6 && k <= 8);
      td = (k >= 1 && k <= 4) ? 8'h70 + 8'(k - 1) : 8'h80 + 8'(k - 6);
      tl = (k == 4 || k == 8);
      tick();
      chk("conc_level", 32'(level), 32'(c_lvl[k]));
      chk("conc_avalid", 32'(avalid), 32'(c_val[k]));
      if (c_val[k]) begin
        chk("conc_adata", 32'(adata), 32'(c_dat[k]));
        chk("conc_alast", 32'(alast), 32'(c_lst[k]));
      end
    end
    {xfer, tv, tl} = '0;
    atready = 1'b0;
`ifdef BULK_EP_OUT_PKT_STATS_EN
    chk("conc_pkt_cnt", 32'(pkt_cnt), 5);
`endif

    // Mid-packet reset
    start();
    put(8'h90, 1'b0);
    tv = 1'b1;
    td = 8'h91;
    rst_n = 1'b0;
    tick();
    reset_vals("midrst");
`ifdef BULK_EP_OUT_PKT_STATS_EN
    chk("midrst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 0);
`endif
    tv = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
